// File: rtl/micro_sequencer.sv
// micro_sequencer: expands CALL/RET into micro-op sequences and tags the immediate word
// of two-word instructions. Define SEQ_RTI_EN to also expand RTI into POPF/POPPcLow/POPPchigh.
module micro_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] InstrOpcode,
    input  logic       InstrValid,
    input  logic       stallLD,
    input  logic       Flush,
    output logic [5:0] Opcode,
    output logic       FirstBit,
    output logic       HoldFetch,
    output logic       SeqBusy
);

    localparam int unsigned OP_W = 6;

    localparam logic [OP_W-1:0] OP_NOP    = 6'b001_000;
    localparam logic [OP_W-1:0] OP_CALL   = 6'b011_100;
    localparam logic [OP_W-1:0] OP_PUSH_H = 6'b111_010;
    localparam logic [OP_W-1:0] OP_PUSH_L = 6'b111_011;
    localparam logic [OP_W-1:0] OP_POP_H  = 6'b011_110;
    localparam logic [OP_W-1:0] OP_POP_L  = 6'b011_111;
    localparam logic [OP_W-1:0] OP_RET    = 6'b110_000;
    localparam logic [OP_W-1:0] OP_LDM    = 6'b010_010;
    localparam logic [OP_W-1:0] OP_SHL    = 6'b000_101;
    localparam logic [OP_W-1:0] OP_SHR    = 6'b000_110;

`ifdef SEQ_RTI_EN
    localparam logic [OP_W-1:0] OP_POPF   = 6'b011_101;
    localparam logic [OP_W-1:0] OP_RTI    = 6'b110_001;
    localparam int unsigned     STEP_W    = 3;
    localparam int unsigned     STEP_MAX  = 4;
`else
    localparam int unsigned     STEP_W    = 2;
    localparam int unsigned     STEP_MAX  = 3;
`endif

    typedef enum logic [3:0] {
        IDLE,
        IMM,
        CALL_L,
        CALL_J,
        RET_H,
        RET_B
`ifdef SEQ_RTI_EN
        ,
        RTI_L,
        RTI_H,
        RTI_B
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [OP_W-1:0]     opcode_d;
    logic                first_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [STEP_W-1:0]   step_inc;
    logic                step_at_max;

    assign step_at_max = (step_q == STEP_W'(STEP_MAX));
    assign step_inc    = step_at_max ? step_q : step_q + STEP_W'(1);

    assign HoldFetch = stallLD | ((state_q != IDLE) && (state_q != IMM));
    assign SeqBusy   = (state_q != IDLE);

    // State, issued micro-op and step counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            Opcode   <= OP_NOP;
            FirstBit <= 1'b0;
            step_q   <= '0;
        end else begin
            state_q  <= state_d;
            Opcode   <= opcode_d;
            FirstBit <= first_d;
            step_q   <= step_d;
        end
    end

    // Priority: Flush, then stall, then watchdog, then the normal sequence step.
    always_comb begin
        state_d  = state_q;
        opcode_d = Opcode;
        first_d  = 1'b0;
        step_d   = step_q;

        if (Flush) begin
            state_d  = IDLE;
            opcode_d = OP_NOP;
            step_d   = '0;
        end else if (stallLD) begin
            state_d  = state_q;
        end else if ((state_q != IDLE) && step_at_max) begin
            state_d  = IDLE;
            opcode_d = OP_NOP;
            step_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!InstrValid) begin
                        opcode_d = OP_NOP;
                    end else begin
                        case (InstrOpcode)
                            OP_CALL: begin
                                opcode_d = OP_PUSH_H;
                                state_d  = CALL_L;
                            end
                            OP_RET: begin
                                opcode_d = OP_POP_L;
                                state_d  = RET_H;
                            end
                            OP_LDM, OP_SHL, OP_SHR: begin
                                opcode_d = InstrOpcode;
                                state_d  = IMM;
                            end
`ifdef SEQ_RTI_EN
                            OP_RTI: begin
                                opcode_d = OP_POPF;
                                state_d  = RTI_L;
                            end
`endif
                            default: opcode_d = InstrOpcode;
                        endcase
                    end
                end
                IMM: begin
                    opcode_d = OP_NOP;
                    first_d  = 1'b1;
                    state_d  = IDLE;
                end
                CALL_L: begin
                    opcode_d = OP_PUSH_L;
                    state_d  = CALL_J;
                end
                CALL_J: begin
                    opcode_d = OP_CALL;
                    state_d  = IDLE;
                end
                RET_H: begin
                    opcode_d = OP_POP_H;
                    state_d  = RET_B;
                end
                RET_B: begin
                    opcode_d = OP_NOP;
                    state_d  = IDLE;
                end
`ifdef SEQ_RTI_EN
                RTI_L: begin
                    opcode_d = OP_POP_L;
                    state_d  = RTI_H;
                end
                RTI_H: begin
                    opcode_d = OP_POP_H;
                    state_d  = RTI_B;
                end
                RTI_B: begin
                    opcode_d = OP_NOP;
                    state_d  = IDLE;
                end
`endif
                default: begin
                    opcode_d = OP_NOP;
                    state_d  = IDLE;
                end
            endcase
            step_d = (state_d == IDLE) ? '0 : step_inc;
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed scoreboard bench for micro_sequencer; follows SEQ_RTI_EN
// to select the RTI expectation.
module tb_micro_sequencer;

    localparam logic [5:0] NOP    = 6'b001_000;
    localparam logic [5:0] CALL   = 6'b011_100;
    localparam logic [5:0] PUSH_H = 6'b111_010;
    localparam logic [5:0] PUSH_L = 6'b111_011;
    localparam logic [5:0] POP_H  = 6'b011_110;
    localparam logic [5:0] POP_L  = 6'b011_111;
    localparam logic [5:0] POPF   = 6'b011_101;
    localparam logic [5:0] RET    = 6'b110_000;
    localparam logic [5:0] RTI    = 6'b110_001;
    localparam logic [5:0] LDM    = 6'b010_010;
    localparam logic [5:0] SHL    = 6'b000_101;
    localparam logic [5:0] SHR    = 6'b000_110;
    localparam logic [5:0] ADD    = 6'b000_001;
    localparam logic [5:0] XORO   = 6'b000_010;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] InstrOpcode;
    logic       InstrValid;
    logic       stallLD;
    logic       Flush;
    logic [5:0] Opcode;
    logic       FirstBit;
    logic       HoldFetch;
    logic       SeqBusy;

    int unsigned total  = 0;
    int unsigned passed = 0;
    logic [6:0]  sb_q[$];

    micro_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .InstrOpcode(InstrOpcode),
        .InstrValid (InstrValid),
        .stallLD    (stallLD),
        .Flush      (Flush),
        .Opcode     (Opcode),
        .FirstBit   (FirstBit),
        .HoldFetch  (HoldFetch),
        .SeqBusy    (SeqBusy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=no_finish required=finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] want);
        total++;
        assert (obs === want) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    endtask

    // One clock: drive inputs, check combinational flags, push expectation, pop after the edge.
    task automatic cyc(input string tag, input logic [5:0] op, input logic v, input logic s,
                       input logic f, input logic [5:0] e_op, input logic e_fb,
                       input logic e_hold, input logic e_busy);
        logic [6:0] e;
        InstrOpcode = op;
        InstrValid  = v;
        stallLD     = s;
        Flush       = f;
        #1;
        check({tag, "/hold"}, 8'(HoldFetch), 8'(e_hold));
        check({tag, "/busy"}, 8'(SeqBusy), 8'(e_busy));
        sb_q.push_back({e_op, e_fb});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check({tag, "/op"}, 8'(Opcode), 8'(e[6:1]));
        check({tag, "/fb"}, 8'(FirstBit), 8'(e[0]));
    endtask

    initial begin
        rst         = 1'b1;
        InstrOpcode = '0;
        InstrValid  = 1'b0;
        stallLD     = 1'b0;
        Flush       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst/op", 8'(Opcode), 8'(NOP));
        check("rst/fb", 8'(FirstBit), 8'd0);
        check("rst/busy", 8'(SeqBusy), 8'd0);
        check("rst/hold0", 8'(HoldFetch), 8'd0);
        stallLD = 1'b1;
        #1;
        check("rst/hold1", 8'(HoldFetch), 8'd1);
        stallLD = 1'b0;
        rst     = 1'b0;

        // Single-cycle pass-through and bubble
        cyc("add",    ADD, 1, 0, 0, ADD, 0, 0, 0);
        cyc("bub0",   ADD, 0, 0, 0, NOP, 0, 0, 0);

        // CALL expansion
        cyc("call0",  CALL, 1, 0, 0, PUSH_H, 0, 0, 0);
        cyc("call1",  CALL, 1, 0, 0, PUSH_L, 0, 1, 1);
        cyc("call2",  CALL, 1, 0, 0, CALL,   0, 1, 1);
        cyc("call3",  CALL, 0, 0, 0, NOP,    0, 0, 0);

        // LDM + immediate; the immediate bits look like RET but must be consumed as data
        cyc("ldm0",   LDM, 1, 0, 0, LDM, 0, 0, 0);
        cyc("ldm1",   RET, 1, 0, 0, NOP, 1, 0, 1);
        cyc("ldm2",   RET, 0, 0, 0, NOP, 0, 0, 0);
        cyc("shl0",   SHL, 1, 0, 0, SHL, 0, 0, 0);
        cyc("shl1",   CALL, 1, 0, 0, NOP, 1, 0, 1);
        cyc("shl2",   ADD, 1, 0, 0, ADD, 0, 0, 0);

        // RET with a load-use stall in RET_H
        cyc("ret0",   RET, 1, 0, 0, POP_L, 0, 0, 0);
        cyc("ret1",   RET, 1, 1, 0, POP_L, 0, 1, 1);
        cyc("ret2",   RET, 1, 0, 0, POP_H, 0, 1, 1);
        cyc("ret3",   RET, 1, 0, 0, NOP,   0, 1, 1);
        cyc("ret4",   RET, 0, 0, 0, NOP,   0, 0, 0);

        // Flush mid-CALL aborts the jump
        cyc("cfl0",   CALL, 1, 0, 0, PUSH_H, 0, 0, 0);
        cyc("cfl1",   CALL, 1, 0, 1, NOP,    0, 1, 1);
        cyc("cfl2",   CALL, 0, 0, 0, NOP,    0, 0, 0);

        // Flush beats stall inside IMM
        cyc("ifl0",   SHR, 1, 0, 0, SHR, 0, 0, 0);
        cyc("ifl1",   ADD, 1, 1, 1, NOP, 0, 1, 1);
        cyc("ifl2",   ADD, 1, 0, 0, ADD, 0, 0, 0);

        // Stall in IDLE freezes Opcode, then stall inside IMM defers FirstBit
        cyc("ist0",   XORO, 1, 1, 0, ADD,  0, 1, 0);
        cyc("ist1",   XORO, 1, 0, 0, XORO, 0, 0, 0);
        cyc("mst0",   LDM, 1, 0, 0, LDM, 0, 0, 0);
        cyc("mst1",   ADD, 1, 1, 0, LDM, 0, 1, 1);
        cyc("mst2",   ADD, 1, 0, 0, NOP, 1, 0, 1);
        cyc("mst3",   ADD, 0, 0, 0, NOP, 0, 0, 0);

        // RTI: sequence only when enabled, otherwise a plain opcode
`ifdef SEQ_RTI_EN
        cyc("rti0",   RTI, 1, 0, 0, POPF,  0, 0, 0);
        cyc("rti1",   RTI, 1, 0, 0, POP_L, 0, 1, 1);
        cyc("rti2",   RTI, 1, 0, 0, POP_H, 0, 1, 1);
        cyc("rti3",   RTI, 1, 0, 0, NOP,   0, 1, 1);
        cyc("rti4",   RTI, 0, 0, 0, NOP,   0, 0, 0);
`else
        cyc("rti0",   RTI, 1, 0, 0, RTI, 0, 0, 0);
        cyc("rti1",   RTI, 0, 0, 0, NOP, 0, 0, 0);
`endif

        // Asynchronous reset in CALL_J abandons the final micro-op
        cyc("rcj0",   CALL, 1, 0, 0, PUSH_H, 0, 0, 0);
        cyc("rcj1",   CALL, 1, 0, 0, PUSH_L, 0, 1, 1);
        rst = 1'b1;
        #1;
        check("rcj/op_async", 8'(Opcode), 8'(NOP));
        check("rcj/busy_async", 8'(SeqBusy), 8'd0);
        check("rcj/hold_async", 8'(HoldFetch), 8'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("rcj2",   CALL, 0, 0, 0, NOP, 0, 0, 0);
        cyc("rcj3",   ADD,  1, 0, 0, ADD, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-high reset: clk rises, rst asserted takes effect immediately without waiting for a clock edge.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-004 Port InstrOpcode, input, 6 bits: opcode field of the word currently presented by fetch.
REQ-005 Port InstrValid, input, 1 bit: InstrOpcode is a real instruction; 0 means a bubble.
REQ-006 Port stallLD, input, 1 bit: load-use stall from hazard detection.
REQ-007 Port Flush, input, 1 bit: taken branch; abort the current sequence.
REQ-008 Port Opcode, output, 6 bits: registered opcode driven into the control unit.
REQ-009 Port FirstBit, output, 1 bit: registered; high on the cycle that the immediate word of a two-word instruction issues.
REQ-010 Port HoldFetch, output, 1 bit: combinational; when high, fetch holds PC and the current InstrOpcode.
REQ-011 Port SeqBusy, output, 1 bit: combinational; high when state is not IDLE.

Function
REQ-012 States SHALL be IDLE, IMM, CALL_L, CALL_J, RET_H, RET_B, RTI_L, RTI_H and RTI_B.
REQ-013 Encodings SHALL be: NOP 001_000, CALL 011_100, pushPChighCall 111_010, pushPClowCall 111_011, POPPchigh 011_110, POPPcLow 011_111, POPF 011_101, RET 110_000, RTI 110_001, LDM 010_010, SHL 000_101, SHR 000_110.
REQ-014 IDLE, InstrValid=0: Opcode<=NOP; stay in IDLE.
REQ-015 IDLE, any valid opcode not listed below: Opcode<=InstrOpcode; stay in IDLE; latency is 1 cycle.
REQ-016 IDLE, LDM/SHL/SHR: Opcode<=InstrOpcode, then go to IMM.
REQ-017 IMM: Opcode<=NOP, FirstBit<=1, then go to IDLE; the word presented during IMM is consumed as immediate data.
REQ-018 IDLE, CALL: Opcode<=111_010, then go to CALL_L.
REQ-019 CALL_L: Opcode<=111_011, then go to CALL_J.
REQ-020 CALL_J: Opcode<=011_100, then go to IDLE.
REQ-021 IDLE, RET: Opcode<=011_111, then go to RET_H.
REQ-022 RET_H: Opcode<=011_110, then go to RET_B.
REQ-023 RET_B: Opcode<=NOP, then go to IDLE.
REQ-024 FirstBit SHALL be 0 in every cycle except the one following the IMM state.
REQ-025 HoldFetch SHALL be stallLD OR (state not IDLE and state not IMM).
REQ-026 stallLD=1 with Flush=0: freeze the state and Opcode, force FirstBit<=0, and consume no input.
REQ-027 Flush=1: state<=IDLE, Opcode<=NOP, FirstBit<=0; Flush has priority over stallLD and over every sequence step, including mid-CALL and IMM.
REQ-028 A 2-bit step counter SHALL count issued micro-ops within a sequence; it clears in IDLE and saturates at 3.
REQ-029 When the counter reaches 3 with the state not IDLE, the block SHALL force IDLE on the next cycle (watchdog).

Reset
REQ-030 While rst=1: state=IDLE, Opcode=NOP (001_000), FirstBit=0, step counter=0.
REQ-031 After release, HoldFetch=stallLD and SeqBusy=0.
REQ-032 Reset asserted mid-sequence SHALL abandon the sequence; no remaining micro-op issues.

Configuration
REQ-033 Macro SEQ_RTI_EN: when defined, RTI in IDLE SHALL issue POPF, then POPPcLow, then POPPchigh, then NOP via RTI_L, RTI_H and RTI_B.
REQ-034 With SEQ_RTI_EN defined, the step counter SHALL widen to 3 bits and the watchdog limit SHALL become 4.
REQ-035 Without SEQ_RTI_EN, RTI SHALL be passed through as an ordinary opcode per REQ-015, and the RTI states SHALL not exist.

Verification
REQ-036 Reset, then ADD (000_001) valid for 1 cycle -> Opcode=000_001 one cycle later; HoldFetch=0 throughout.
REQ-037 CALL -> Opcode 111_010, 111_011, 011_100 on consecutive cycles; HoldFetch=1 for the first two cycles; SeqBusy=1 for 2 cycles.
REQ-038 LDM then immediate word 0x1234 -> Opcode 010_010 followed by NOP with FirstBit=1; HoldFetch=0 on both cycles.
REQ-039 RET with stallLD=1 during the RET_H cycle -> 011_111 is held an extra cycle, then 011_110, then NOP.
REQ-040 CALL with Flush=1 during CALL_L -> next Opcode=NOP, state IDLE, 011_100 never issues.
REQ-041 rst pulse during CALL_J -> Opcode=NOP immediately; SEQ_RTI_EN build: RTI -> 011_101, 011_111, 011_110, NOP.
